// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/HALT control unit for the 16-bit RISC core.
// Control outputs are registered from the next-state decode, so they are valid for the whole state.
module control_sequencer #(
  parameter logic [5:0] RESET_PC  = 6'd0,
  parameter logic [3:0] FS_PASS_A = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] imem_data,
  input  logic [5:0]  a_in,
  input  logic        N,
  input  logic        Z,
  output logic [5:0]  pc,
  output logic        MD,
  output logic        RW,
  output logic        ASEL,
  output logic [1:0]  MB,
  output logic [3:0]  FS,
  output logic [3:0]  SA,
  output logic [3:0]  DR,
  output logic [3:0]  BA,
  output logic [15:0] imdt,
  output logic        ram_we,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        md_q, md_d, rw_q, rw_d, asel_q, asel_d, we_q, we_d, halted_q, halted_d;
  logic [1:0]  mb_q, mb_d;
  logic [3:0]  fs_q, fs_d, sa_q, sa_d, dr_q, dr_d, ba_q, ba_d;
  logic [15:0] imdt_q, imdt_d;
  logic [3:0]  op_d;

  // Sequencing: state, program counter and instruction register.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = imem_data;
        pc_d    = pc_q + 6'd1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_q[15:12])
          4'h9: state_d = S_MEM;
          4'hB: pc_d = ir_q[5:0];
          4'hC: if (Z) pc_d = ir_q[5:0]; else pc_d = pc_q;
          4'hD: if (N) pc_d = ir_q[5:0]; else pc_d = pc_q;
          4'hE: pc_d = a_in;
          4'hF: state_d = S_HALT;
          default: pc_d = pc_q;
        endcase
      end
      S_MEM:   state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Control decode for the state being entered, using the IR it will hold.
  always_comb begin
    op_d     = ir_d[15:12];
    md_d     = 1'b0;
    rw_d     = 1'b0;
    asel_d   = 1'b0;
    mb_d     = 2'd0;
    fs_d     = 4'd0;
    sa_d     = 4'd0;
    dr_d     = 4'd0;
    ba_d     = 4'd0;
    imdt_d   = 16'h0000;
    we_d     = 1'b0;
    halted_d = 1'b0;
    case (state_d)
      S_EXEC: begin
        sa_d = ir_d[7:4];
        dr_d = ir_d[11:8];
        ba_d = ir_d[3:0];
        case (op_d)
          4'h8: begin
            imdt_d = {8'h00, ir_d[7:0]};
            mb_d   = 2'd1;
            rw_d   = 1'b1;
          end
          4'h9: rw_d = 1'b0;
          4'hA: we_d = 1'b1;
          4'hB: begin
            mb_d = 2'd2;
            rw_d = 1'b1;
          end
          4'hC, 4'hD: begin
            sa_d = ir_d[11:8];
            fs_d = FS_PASS_A;
          end
          4'hE: fs_d = FS_PASS_A;
          4'hF: rw_d = 1'b0;
          default: begin
            fs_d = {1'b0, op_d[2:0]};
            rw_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        sa_d = ir_d[7:4];
        dr_d = ir_d[11:8];
        ba_d = ir_d[3:0];
        md_d = 1'b1;
        rw_d = 1'b1;
      end
      S_HALT:  halted_d = 1'b1;
      default: halted_d = 1'b0;
    endcase
  end

  // State and registered control outputs; reset aborts any in-flight instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 16'h0000;
      md_q     <= 1'b0;
      rw_q     <= 1'b0;
      asel_q   <= 1'b0;
      mb_q     <= 2'd0;
      fs_q     <= 4'd0;
      sa_q     <= 4'd0;
      dr_q     <= 4'd0;
      ba_q     <= 4'd0;
      imdt_q   <= 16'h0000;
      we_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      md_q     <= md_d;
      rw_q     <= rw_d;
      asel_q   <= asel_d;
      mb_q     <= mb_d;
      fs_q     <= fs_d;
      sa_q     <= sa_d;
      dr_q     <= dr_d;
      ba_q     <= ba_d;
      imdt_q   <= imdt_d;
      we_q     <= we_d;
      halted_q <= halted_d;
    end
  end

  assign pc     = pc_q;
  assign MD     = md_q;
  assign RW     = rw_q;
  assign ASEL   = asel_q;
  assign MB     = mb_q;
  assign FS     = fs_q;
  assign SA     = sa_q;
  assign DR     = dr_q;
  assign BA     = ba_q;
  assign imdt   = imdt_q;
  assign ram_we = we_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: instruction-level reference model driven by
// directed programs and random ROM contents, with random flags and JR targets.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] imem_data;
  logic [5:0]  a_in = 6'd0;
  logic        N = 1'b0;
  logic        Z = 1'b0;
  logic [5:0]  pc;
  logic        MD, RW, ASEL, ram_we, halted;
  logic [1:0]  MB;
  logic [3:0]  FS, SA, DR, BA;
  logic [15:0] imdt;

  logic [15:0] rom [64];
  int checks = 0;
  int errors = 0;
  int zmode  = 0;

  assign imem_data = rom[pc];

  control_sequencer dut (
    .clk(clk), .reset(reset), .imem_data(imem_data), .a_in(a_in), .N(N), .Z(Z),
    .pc(pc), .MD(MD), .RW(RW), .ASEL(ASEL), .MB(MB), .FS(FS), .SA(SA), .DR(DR),
    .BA(BA), .imdt(imdt), .ram_we(ram_we), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] ctl_obs();
    return {MD, RW, ASEL, MB, FS, SA, DR, BA, imdt, ram_we};
  endfunction

  // Expected EXEC-cycle control bundle, straight from the instruction table.
  function automatic logic [37:0] exp_exec(input logic [15:0] ir);
    logic md, rw, asel, we;
    logic [1:0] mb;
    logic [3:0] fs, sa, dr, ba;
    logic [15:0] im;
    int op;
    op = int'(ir[15:12]);
    md = 1'b0; rw = 1'b0; asel = 1'b0; we = 1'b0; mb = 2'd0; fs = 4'd0; im = 16'h0000;
    sa = ir[7:4]; dr = ir[11:8]; ba = ir[3:0];
    if (op < 8) begin
      fs = 4'(op);
      rw = 1'b1;
    end else if (op == 8) begin
      im = {8'h00, ir[7:0]};
      mb = 2'd1;
      rw = 1'b1;
    end else if (op == 10) begin
      we = 1'b1;
    end else if (op == 11) begin
      mb = 2'd2;
      rw = 1'b1;
    end else if (op == 12 || op == 13) begin
      sa = ir[11:8];
    end
    return {md, rw, asel, mb, fs, sa, dr, ba, im, we};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs the ROM from reset release, checking every cycle against the model.
  task automatic run_program(input int max_instr);
    logic [15:0] mir;
    logic [5:0]  mpc;
    logic [37:0] mask;
    int n;
    bit done;
    int op;
    mask = '1;
    mask[28:25] = 4'h0;
    mask[20:17] = 4'h0;
    mpc = 6'd0;
    n = 0;
    done = 1'b0;
    while (!done && n < max_instr) begin
      #1;
      chk("fetch_ctl", 64'(ctl_obs()), 64'd0);
      chk("fetch_pc", 64'(pc), 64'(mpc));
      chk("fetch_halted", 64'(halted), 64'd0);
      mir = rom[mpc];
      mpc = mpc + 6'd1;
      op = int'(mir[15:12]);
      @(negedge clk);
      #1;
      chk("exec_ctl", 64'(ctl_obs()), 64'(exp_exec(mir)));
      chk("exec_pc", 64'(pc), 64'(mpc));
      chk("exec_halted", 64'(halted), 64'd0);
      Z = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      N = 1'($urandom_range(0, 1));
      a_in = 6'($urandom_range(0, 63));
      if (op == 11) mpc = mir[5:0];
      else if (op == 12 && Z) mpc = mir[5:0];
      else if (op == 13 && N) mpc = mir[5:0];
      else if (op == 14) mpc = a_in;
      @(negedge clk);
      if (op == 9) begin
        #1;
        chk("mem_ctl", 64'(ctl_obs() & mask),
            64'({1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, mir[11:8], 4'd0, 16'h0000, 1'b0}));
        chk("mem_pc", 64'(pc), 64'(mpc));
        @(negedge clk);
      end
      if (op == 15) begin
        for (int k = 0; k < 3; k++) begin
          #1;
          chk("halt_halted", 64'(halted), 64'd1);
          chk("halt_pc", 64'(pc), 64'(mpc));
          chk("halt_ctl", 64'(ctl_obs()), 64'd0);
          @(negedge clk);
        end
        done = 1'b1;
      end
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill_rom(input logic [15:0] v);
    for (int i = 0; i < 64; i++) rom[i] = v;
  endtask

  initial begin
    fill_rom(16'hF000);
    #1;
    chk("reset_ctl", 64'(ctl_obs()), 64'd0);
    chk("reset_pc", 64'(pc), 64'd0);
    chk("reset_halted", 64'(halted), 64'd0);
    @(negedge clk);

    // LDI R1,0x5A then HLT
    rom[0] = 16'h815A;
    rom[1] = 16'hF000;
    release_reset();
    run_program(4);

    // ALU op3, LD, BZ with Z forced high then low
    fill_rom(16'hF000);
    rom[0] = 16'h3211;
    rom[1] = 16'h9410;
    rom[2] = 16'hC010;
    rom[3] = 16'h8C07;
    zmode = 1;
    release_reset();
    run_program(8);
    zmode = 2;
    release_reset();
    run_program(8);
    zmode = 0;

    // JAL R7,0x3F at pc 5, then wrap to 0 on the following fetch
    fill_rom(16'hF000);
    for (int i = 0; i < 5; i++) rom[i] = 16'h0123 + 16'(i);
    rom[5]  = 16'hB73F;
    rom[63] = 16'hF000;
    release_reset();
    run_program(10);

    // Reset during EXEC of ST aborts the strobe immediately
    fill_rom(16'hF000);
    rom[0] = 16'hA012;
    release_reset();
    #1;
    chk("st_fetch_pc", 64'(pc), 64'd0);
    @(negedge clk);
    #1;
    chk("st_exec_we", 64'(ram_we), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("st_abort_we", 64'(ram_we), 64'd0);
    chk("st_abort_rw", 64'(RW), 64'd0);
    chk("st_abort_pc", 64'(pc), 64'd0);
    @(negedge clk);
    release_reset();
    run_program(4);

    // Random programs with random flags and JR targets
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 64; i++) rom[i] = 16'($urandom);
      release_reset();
      run_program(40);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
